// File: rtl/m_tic_pkg.sv
// Shared types and default constants for the tic period checker.
package m_tic_pkg;

  // Checker FSM: waiting for a first tic, timing toward lock, or locked.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } tic_state_e;

  localparam int DEF_MAXCOUNT = 99_999;
  localparam int DEF_TOL      = 0;
  localparam int DEF_LOCK_N   = 4;
  localparam int DEF_CNT_W    = 16;

  // Width that can hold every gap value up to the saturation point P+TOL+1.
  function automatic int gap_width(input int maxcount, input int tol);
    return $clog2(maxcount + 1 + tol + 2);
  endfunction

endpackage : m_tic_pkg

// File: rtl/m_tic_gap_cnt.sv
// Saturating gap counter: loads 1 on clear, otherwise counts up to sat_val and holds.
module m_tic_gap_cnt
  import m_tic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] sat_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: restart at 1 after a tic, else increment until saturated.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch.
    count_d = count_q;
    if (clear) begin
      count_d = W'(1);
    end else if (count_q < sat_val) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for flops so all registers update together.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : m_tic_gap_cnt

// File: rtl/m_tic_checker.sv
// Watches a periodic one-cycle tic and reports lock, early/late errors,
// the running tic count and the last measured gap.
module m_tic_checker
  import m_tic_pkg::*;
#(
  parameter int MAXCOUNT = DEF_MAXCOUNT,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_N   = DEF_LOCK_N,
  parameter int CNT_W    = DEF_CNT_W,
  localparam int GAP_W   = gap_width(MAXCOUNT, TOL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tic,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic [CNT_W-1:0] tic_count,
  output logic [GAP_W-1:0] last_gap
);

  localparam int P    = MAXCOUNT + 1;
  localparam int GR_W = $clog2(LOCK_N + 1);

  // Gap thresholds: good window is [P-TOL, P+TOL]; P+TOL+1 means late.
  localparam logic [GAP_W-1:0] LO_V  = GAP_W'(P - TOL);
  localparam logic [GAP_W-1:0] SAT_V = GAP_W'(P + TOL + 1);
  localparam logic [GR_W-1:0]  LOCK_V = GR_W'(LOCK_N);

  logic [GAP_W-1:0] gap_cnt;

  tic_state_e       state_q,     state_d;
  logic [GR_W-1:0]  good_run_q,  good_run_d;
  logic             locked_q,    locked_d;
  logic             err_early_q, err_early_d;
  logic             err_late_q,  err_late_d;
  logic [CNT_W-1:0] tic_count_q, tic_count_d;
  logic [GAP_W-1:0] last_gap_q,  last_gap_d;

  // Every tic restarts gap timing, whatever the FSM state.
  m_tic_gap_cnt #(
    .W(GAP_W)
  ) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (tic),
    .sat_val(SAT_V),
    .count  (gap_cnt)
  );

  // Next-state and output decode: classify each tic (or missing tic) by gap.
  always_comb begin
    state_d     = state_q;
    good_run_d  = good_run_q;
    err_early_d = 1'b0;
    err_late_d  = 1'b0;
    tic_count_d = tic_count_q;
    last_gap_d  = last_gap_q;

    // Bookkeeping applies to every tic; gap_cnt is already saturated.
    if (tic) begin
      tic_count_d = tic_count_q + CNT_W'(1);
      last_gap_d  = gap_cnt;
    end

    unique case (state_q)
      IDLE: begin
        if (tic) begin
          state_d    = MEASURE;
          good_run_d = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (gap_cnt >= SAT_V) begin
          // Late wins over early; a coinciding tic restarts timing from itself.
          err_late_d = 1'b1;
          good_run_d = '0;
          state_d    = tic ? MEASURE : IDLE;
        end else if (tic) begin
          if (gap_cnt < LO_V) begin
            err_early_d = 1'b1;
            good_run_d  = '0;
            state_d     = MEASURE;
          end else if (good_run_q >= LOCK_V - GR_W'(1)) begin
            good_run_d = LOCK_V;
            state_d    = LOCKED;
          end else begin
            good_run_d = good_run_q + GR_W'(1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        good_run_d = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  // FSM and registered outputs, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      good_run_q  <= '0;
      locked_q    <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      tic_count_q <= '0;
      last_gap_q  <= '0;
    end else begin
      state_q     <= state_d;
      good_run_q  <= good_run_d;
      locked_q    <= locked_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      tic_count_q <= tic_count_d;
      last_gap_q  <= last_gap_d;
    end
  end

  assign locked    = locked_q;
  assign err_early = err_early_q;
  assign err_late  = err_late_q;
  assign tic_count = tic_count_q;
  assign last_gap  = last_gap_q;

endmodule : m_tic_checker

// File: doc/m_tic_checker.md
M_TIC_CHECKER -- requirements
Module: m_tic_checker

Interface
REQ-001 SHALL have parameter MAXCOUNT, default 99_999, meaning expected tic period P = MAXCOUNT+1 clk cycles (matches m_counter).
REQ-002 SHALL have parameter TOL, default 0, meaning allowed gap deviation in cycles, ±TOL; TOL < P-1.
REQ-003 SHALL have parameter LOCK_N, default 4, meaning consecutive good gaps required to assert locked; LOCK_N ≥ 1.
REQ-004 SHALL have parameter CNT_W, default 16, meaning tic_count width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-007 SHALL have port tic, input, 1, meaning a one-cycle pulse from m_counter, sampled every clk edge; each high cycle is one tic event.
REQ-008 SHALL have port locked, output, 1, meaning a level that is high while the tic period is verified in-spec.
REQ-009 SHALL have port err_early, output, 1, meaning a one-cycle pulse when a tic arrives with gap < P-TOL.
REQ-010 SHALL have port err_late, output, 1, meaning a one-cycle pulse when no tic arrives within P+TOL cycles.
REQ-011 SHALL have port tic_count, output, CNT_W, meaning the total number of tics accepted since reset; it wraps modulo 2^CNT_W.
REQ-012 SHALL have port last_gap, output, GAP_W, meaning the most recent measured gap in cycles; GAP_W = $clog2(P+TOL+2).

Function
REQ-013 SHALL define gap as the number of clk edges from one tic sample to the next; the gap for m_counter output = P.
REQ-014 SHALL keep an internal gap_cnt: set to 1 on the cycle after a tic, +1 per cycle without tic, saturating at P+TOL+1.
REQ-015 SHALL implement an FSM with states IDLE (awaiting first tic), MEASURE (timing, not locked) and LOCKED.
REQ-016 In IDLE, a tic SHALL go to MEASURE, clear good_run and start gap_cnt, with no error check.
REQ-017 In MEASURE/LOCKED, a tic with P-TOL ≤ gap ≤ P+TOL SHALL be good: good_run+1; when good_run reaches LOCK_N, go to LOCKED.
REQ-018 A tic with gap < P-TOL SHALL pulse err_early, clear good_run, go to MEASURE (leaving LOCKED), and restart gap_cnt from this tic.
REQ-019 When gap reaches P+TOL+1 with no tic SHALL pulse err_late once, clear good_run and go to IDLE.
REQ-020 A tic coinciding with the late threshold (gap = P+TOL+1) SHALL pulse err_late (not err_early) and go to MEASURE, restarting timing from this tic.
REQ-021 SHALL update last_gap and tic_count+1 on every tic, including tics in IDLE and erroneous ones; last_gap saturates at P+TOL+1.
REQ-022 SHALL register all outputs; the response to a tic sampled at edge N appears after edge N+1 (latency 1).
REQ-023 SHALL keep locked = (state == LOCKED), registered; it drops the same cycle err_early/err_late pulses.
REQ-024 If tic is held high continuously, each cycle after the first SHALL count as a tic with gap 1, giving err_early each cycle (if P-TOL > 1).
REQ-025 SHALL never assert err_early and err_late in the same cycle.

Reset
REQ-026 While rst=1 the FSM SHALL go to IDLE; locked, err_early, err_late, tic_count, last_gap, gap_cnt and good_run SHALL be 0; tic SHALL be ignored.
REQ-027 Reset asserted mid-interval or in LOCKED SHALL take effect at the next edge; after release, the first tic SHALL be treated as the IDLE first tic.

Structure
REQ-028 Package m_tic_pkg SHALL hold the FSM state enum (IDLE, MEASURE, LOCKED) and the default constants MAXCOUNT=99_999, TOL=0 and LOCK_N=4.
REQ-029 The saturating gap counter SHALL be one sub-module, m_tic_gap_cnt, with ports clk, rst, clear, sat_val and count; everything else lives in the top level.

Verification (MAXCOUNT=9 → P=10, TOL=1, LOCK_N=3)
REQ-030 Reset held 5 cycles with tic pulses → all outputs 0 throughout; after release, first tic → tic_count=1 with no error.
REQ-031 Tics every 10 cycles ×4 → locked=1 one cycle after the 4th tic; tic_count=4, last_gap=10, no error pulses.
REQ-032 Gaps of 9 then 11 (tolerance edges) → no errors, good_run advances; a gap of 8 → err_early for 1 cycle, locked 0, last_gap=8.
REQ-033 Locked, then no tic → err_late for 1 cycle, 12 cycles after the last tic; locked 0, state IDLE; the next tic gives no error.
REQ-034 Tic exactly at gap 12 → err_late only, state MEASURE; the following tic 10 cycles later counts as good.
REQ-035 rst pulsed in LOCKED mid-interval → next cycle locked=0, tic_count=0, last_gap=0; tic held high 4 cycles → err_early on cycles 2–4.
